// File: rtl/aes_ct_capture.sv
// Captures each completed AES ciphertext into a small FIFO and streams every
// entry out as four 32-bit words (least significant word first) on valid/ready.
module aes_ct_capture #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [127:0]          ct_i,
  input  logic                  ct_valid_i,
  input  logic                  clear_i,
  input  logic                  lock_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [CW-1:0]         count_o,
  output logic                  overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [127:0]          mem_reg [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [1:0]            word_idx_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg;
  logic                  prev_valid_reg;

  logic                  cap;
  logic                  xfer;
  logic                  pop;
  logic                  full;
  logic                  cap_accepted;
  logic [127:0]          head;
  logic [DATA_WIDTH-1:0] head_words [4];

  assign cap          = ct_valid_i & ~prev_valid_reg;
  assign full         = (count_reg == CW'(DEPTH));
  assign out_valid_o  = (count_reg != '0) & ~lock_i;
  assign xfer         = out_valid_o & out_ready_i;
  assign pop          = xfer & (word_idx_reg == 2'd3);
  // A pop in the same cycle frees the slot, so a capture at full still fits.
  assign cap_accepted = cap & (~full | pop);

  assign head = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign head_words[gi] = head[32*gi +: 32];
    end
  endgenerate

  // Data is forced to zero whenever the stream is not valid (locked or empty).
  assign out_data_o = out_valid_o ? head_words[word_idx_reg] : '0;
  assign out_last_o = out_valid_o & (word_idx_reg == 2'd3);
  assign count_o    = count_reg;
  assign overflow_o = overflow_reg;

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (!clear_i && cap_accepted) begin
      mem_reg[wr_ptr_reg] <= ct_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      word_idx_reg   <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      prev_valid_reg <= 1'b0;
    end else begin
      prev_valid_reg <= ct_valid_i;
      if (clear_i) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        word_idx_reg <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (cap_accepted) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (cap && !cap_accepted) begin
          overflow_reg <= 1'b1;
        end
        if (xfer) begin
          word_idx_reg <= word_idx_reg + 2'd1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        count_reg <= count_reg + CW'(cap_accepted) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_aes_ct_capture.sv
// Directed and random stimulus for aes_ct_capture, checked against a queue-based
// reference model of the ciphertext FIFO and its word stream.
module tb_aes_ct_capture;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [127:0]  ct_i;
  logic          ct_valid_i;
  logic          clear_i;
  logic          lock_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   out_data_o;
  logic          out_last_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [127:0] m_q [$];
  int           m_idx;
  bit           m_ovf;
  bit           m_prev;

  logic [127:0] saved_ct;

  aes_ct_capture #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ct_i        (ct_i),
    .ct_valid_i  (ct_valid_i),
    .clear_i     (clear_i),
    .lock_i      (lock_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_idx  = 0;
    m_ovf  = 0;
    m_prev = 0;
  endtask

  task automatic check_outputs(input string tag);
    bit          ev;
    logic [31:0] ed;
    ev = (m_q.size() != 0) && !lock_i;
    ed = ev ? m_q[0][32*m_idx +: 32] : 32'h0;
    check({tag, ".valid"}, 128'(out_valid_o), 128'(ev));
    check({tag, ".data"},  128'(out_data_o),  128'(ed));
    check({tag, ".last"},  128'(out_last_o),  128'(ev && (m_idx == 3)));
    check({tag, ".count"}, 128'(count_o),     128'(m_q.size()));
    check({tag, ".ovf"},   128'(overflow_o),  128'(m_ovf));
  endtask

  // Check outputs, cross one clock edge, apply the same rules to the model.
  task automatic step(input string tag);
    bit cap, xfer, pop, had_room;
    #1;
    check_outputs(tag);
    @(posedge clk_i);
    cap  = ct_valid_i && !m_prev;
    xfer = (m_q.size() != 0) && !lock_i && out_ready_i;
    if (clear_i) begin
      m_q.delete();
      m_idx = 0;
      m_ovf = 0;
    end else begin
      had_room = m_q.size() < DEPTH;
      pop = xfer && (m_idx == 3);
      if (xfer) m_idx = (m_idx + 1) % 4;
      if (pop) void'(m_q.pop_front());
      if (cap) begin
        if (had_room || pop) m_q.push_back(ct_i);
        else m_ovf = 1;
      end
    end
    m_prev = ct_valid_i;
    @(negedge clk_i);
  endtask

  task automatic capture(input string tag, input logic [127:0] data);
    ct_i       = data;
    ct_valid_i = 1'b1;
    step(tag);
    ct_valid_i = 1'b0;
    step(tag);
  endtask

  task automatic do_clear(input string tag);
    clear_i = 1'b1;
    step(tag);
    clear_i = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst_ni      = 1'b0;
    ct_i        = '0;
    ct_valid_i  = 1'b0;
    clear_i     = 1'b0;
    lock_i      = 1'b0;
    out_ready_i = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // T1: one pulse, four words least-significant first
    out_ready_i = 1'b1;
    ct_i        = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    ct_valid_i  = 1'b1;
    step("t1_cap");
    ct_valid_i  = 1'b0;
    #1;
    check("t1_w0_const", 128'(out_data_o), 128'h0CCDDEEFF);
    check("t1_cnt_const", 128'(count_o), 128'd1);
    for (int i = 0; i < 4; i++) step($sformatf("t1_w%0d", i));
    check("t1_empty", 128'(count_o), 128'd0);

    // T2: held level captures only once
    out_ready_i = 1'b0;
    ct_i        = rnd128();
    ct_valid_i  = 1'b1;
    for (int i = 0; i < 10; i++) step("t2_hold");
    ct_valid_i  = 1'b0;
    step("t2_fall");
    check("t2_cnt_const", 128'(count_o), 128'd1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step("t2_drain");

    // T3: overflow with ready low, drain in order, clear
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) capture("t3_cap", rnd128());
    check("t3_cnt_const", 128'(count_o), 128'd4);
    check("t3_ovf_const", 128'(overflow_o), 128'd1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) step("t3_drain");
    do_clear("t3_clear");
    step("t3_after_clear");
    check("t3_ovf_cleared", 128'(overflow_o), 128'd0);

    // T4: capture coincident with the word-3 pop at full
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) capture("t4_fill", rnd128());
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step("t4_words");
    ct_i        = rnd128();
    ct_valid_i  = 1'b1;
    step("t4_coincide");
    ct_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    #1;
    check("t4_cnt_const", 128'(count_o), 128'd4);
    check("t4_ovf_const", 128'(overflow_o), 128'd0);
    step("t4_hold");
    do_clear("t4_clear");

    // T5: lock mid-entry hides data, unlock resumes at word 2
    out_ready_i = 1'b0;
    saved_ct = rnd128();
    capture("t5_cap", saved_ct);
    out_ready_i = 1'b1;
    step("t5_w0");
    step("t5_w1");
    lock_i = 1'b1;
    step("t5_lock");
    step("t5_lock");
    lock_i = 1'b0;
    #1;
    check("t5_resume_w2", 128'(out_data_o), 128'(saved_ct[95:64]));
    for (int i = 0; i < 3; i++) step("t5_rest");

    // T6: async reset mid-entry, then fresh capture from word 0
    out_ready_i = 1'b0;
    capture("t6_cap", rnd128());
    out_ready_i = 1'b1;
    step("t6_w0");
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_outputs("t6_async");
    @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_i = 1'b0;
    saved_ct = rnd128();
    capture("t6_fresh", saved_ct);
    #1;
    check("t6_fresh_w0", 128'(out_data_o), 128'(saved_ct[31:0]));
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step("t6_drain");

    // Random traffic: pulses, backpressure, locks and rare clears
    for (int i = 0; i < 600; i++) begin
      if (!ct_valid_i && ($urandom_range(0, 2) == 0)) begin
        ct_i       = rnd128();
        ct_valid_i = 1'b1;
      end else if (ct_valid_i && ($urandom_range(0, 1) == 0)) begin
        ct_valid_i = 1'b0;
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      lock_i      = ($urandom_range(0, 9) == 0);
      clear_i     = ($urandom_range(0, 49) == 0);
      step("rand");
    end
    clear_i = 1'b0;
    lock_i  = 1'b0;
    step("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
